clock_set_ctrl: RTL
===================

Name: clock_set_ctrl

Overview:
- Mode and time-set controller for the 24-hour clock.
- Consumes the 1 Hz tick, the ~1.9 kHz sample strobe and the 0.5 s blink level from the second-tick generator, plus two raw push-buttons.
- Sequences RUN/SET modes and produces single-cycle increment/clear pulses for the hour, minute and second counters, plus digit-blank controls for the display.
- The carry chain in RUN stays in the downstream counters.

Parameters:
- DEB_N, 8, consecutive equal samples (on KHZ_EN) required to accept a new button level
- REP_DLY, 955, KHZ_EN ticks UP must stay held before auto-repeat starts (~0.5 s)
- REP_PER, 191, KHZ_EN ticks between auto-repeat pulses (~0.1 s)
- TIMEOUT_S, 30, SEC_EN ticks with no debounced press in a SET mode before forced return to RUN

Ports:
- CLK  in  1  system clock, 125 MHz
- RESET  in  1  asynchronous, active-high reset
- SEC_EN  in  1  one-cycle 1 Hz tick
- KHZ_EN  in  1  one-cycle sample strobe
- BLINK  in  1  blink level, high during second half of each second
- BTN_MODE  in  1  raw MODE button, active-high, asynchronous to CLK
- BTN_UP  in  1  raw UP button, active-high, asynchronous to CLK
- MODE  out  2  0=RUN, 1=SET_H, 2=SET_M, 3=SET_S
- SEC_INC  out  1  one-cycle pulse to the seconds counter (RUN only)
- MIN_INC  out  1  one-cycle no-carry increment of minutes
- HOUR_INC  out  1  one-cycle no-carry increment of hours
- SEC_CLR  out  1  one-cycle synchronous clear of seconds
- BLANK_H, BLANK_M, BLANK_S  out  1 each  blank the corresponding digit pair

Behaviour:
- Reset (async, any time, including mid-repeat) forces:
  - MODE=RUN, all pulse outputs 0, all BLANK_x 0
  - debounced levels 0; repeat, debounce and timeout counters 0
- Input sync: each raw button passes a 2-flop synchronizer before debounce.
- Debounce:
  - The synchronized level is sampled only on KHZ_EN cycles.
  - A stability counter reaches DEB_N when the sample has differed from the debounced level on DEB_N consecutive KHZ_EN cycles; the debounced level then flips on that cycle.
  - Any sample equal to the current debounced level zeroes the counter.
  - A debounced 0->1 transition is a press event. An internal press strobe is high for the one cycle after the flip.
- FSM (MODE):
  - On a MODE press: RUN->SET_H->SET_M->SET_S->RUN.
  - On timeout: any SET_x->RUN.
  - MODE updates on the cycle after the press strobe.
- Simultaneous events:
  - MODE press and UP press/repeat in the same cycle: the MODE transition wins and the UP event is dropped.
  - Timeout and MODE press in the same cycle: go to RUN.
- RUN:
  - SEC_INC is asserted exactly one cycle after each SEC_EN.
  - UP is ignored. Other increment outputs are 0.
- SET modes:
  - SEC_INC is held 0, so the clock halts.
  - An UP event is an UP press strobe or an auto-repeat strobe. Response is one cycle after the event:
    - SET_H: HOUR_INC=1
    - SET_M: MIN_INC=1
    - SET_S: SEC_CLR=1
- Auto-repeat (SET_H/SET_M only, never SET_S):
  - While debounced UP=1, a repeat counter advances on KHZ_EN.
  - The first repeat strobe fires REP_DLY ticks after the press, then every REP_PER ticks.
  - The counter is cleared when debounced UP=0 and on any MODE change.
- Timeout:
  - In SET modes a counter increments on SEC_EN and is cleared by any press event (either button).
  - Reaching TIMEOUT_S returns to RUN on the next cycle.
  - The counter is cleared on entry to each SET mode.
- Blanking:
  - BLANK_x=1 only when MODE selects digit x, BLINK=1 and debounced UP=0; otherwise 0.
  - All BLANK_x are registered, so they are one cycle behind their inputs.
- Widths: internal counters are sized to hold their parameter value, with no wrap before the compare. At most one of HOUR_INC/MIN_INC/SEC_CLR/SEC_INC is high in any cycle.

Test Plan:
- Bench parameters: DEB_N=4, REP_DLY=10, REP_PER=3, TIMEOUT_S=3, with KHZ_EN every 4 CLK and SEC_EN every 40 CLK.
- Reset, then RUN, 3 SEC_EN pulses -> SEC_INC is 3 single-cycle pulses, each 1 cycle after SEC_EN; MODE=0; all BLANK_x=0.
- BTN_MODE glitch high for 3 KHZ_EN ticks, then clean press held for 6 ticks -> no transition on the glitch; MODE=1 after the clean press; SEC_INC suppressed while MODE=1.
- In SET_M, hold BTN_UP for 20 KHZ_EN ticks after debounce -> MIN_INC pulses: 1 on press, then repeats at ticks 10, 13, 16, 19 (5 total); HOUR_INC=0.
- In SET_S, press UP -> one SEC_CLR pulse, no auto-repeat when held; BLANK_S follows BLINK delayed 1 cycle while UP is released and stays 0 while UP is held.
- In SET_H with no presses for 3 SEC_EN ticks -> MODE returns to 0 the following cycle. Separately, MODE and UP presses coincident in SET_H -> MODE=2, no HOUR_INC.
- Assert RESET mid auto-repeat in SET_M -> MODE=0 immediately with no pulses; after release, holding UP produces no MIN_INC.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: RUN/SET mode sequencer for the 24-hour clock.
// Debounces MODE/UP, drives set-time increment pulses, auto-repeat, timeout and digit blanking.
module clock_set_ctrl #(
   parameter int DEB_N     = 8,
   parameter int REP_DLY   = 955,
   parameter int REP_PER   = 191,
   parameter int TIMEOUT_S = 30
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       SEC_EN,
   input  logic       KHZ_EN,
   input  logic       BLINK,
   input  logic       BTN_MODE,
   input  logic       BTN_UP,
   output logic [1:0] MODE,
   output logic       SEC_INC,
   output logic       MIN_INC,
   output logic       HOUR_INC,
   output logic       SEC_CLR,
   output logic       BLANK_H,
   output logic       BLANK_M,
   output logic       BLANK_S
);
   localparam int DW = $clog2(DEB_N + 1);
   localparam int RW = $clog2(REP_DLY + 1);
   localparam int TW = $clog2(TIMEOUT_S + 1);
   typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} mode_t;
   mode_t state;
   logic [1:0] sync_m, sync_u;
   logic [DW-1:0] cnt_m, cnt_u;
   logic deb_m, deb_u, deb_m_d, deb_u_d;
   logic [RW-1:0] rep_cnt;
   logic [TW-1:0] to_cnt, to_nxt;
   logic rep_strb, press_m, press_u, in_set, to_hit, mode_chg, rep_hit, up_ev;
   assign MODE     = state;
   assign press_m  = deb_m & ~deb_m_d;
   assign press_u  = deb_u & ~deb_u_d;
   assign in_set   = state != RUN;
   assign to_nxt   = to_cnt + TW'(SEC_EN);
   assign to_hit   = in_set && to_nxt == TW'(TIMEOUT_S);
   assign mode_chg = press_m | to_hit;
   assign rep_hit  = KHZ_EN && rep_cnt == RW'(REP_DLY - 1);
   // A mode change swallows any UP event arriving in the same cycle.
   assign up_ev    = (press_u | (rep_strb & (state == SET_H || state == SET_M))) & ~mode_chg;
   // Level flips on the DEB_N-th consecutive differing sample.
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         sync_m  <= '0;
         sync_u  <= '0;
         cnt_m   <= '0;
         cnt_u   <= '0;
         deb_m   <= 1'b0;
         deb_u   <= 1'b0;
         deb_m_d <= 1'b0;
         deb_u_d <= 1'b0;
      end else begin
         sync_m  <= {sync_m[0], BTN_MODE};
         sync_u  <= {sync_u[0], BTN_UP};
         deb_m_d <= deb_m;
         deb_u_d <= deb_u;
         if (KHZ_EN) begin
            cnt_m <= sync_m[1] == deb_m || cnt_m == DW'(DEB_N - 1) ? '0 : cnt_m + 1'b1;
            cnt_u <= sync_u[1] == deb_u || cnt_u == DW'(DEB_N - 1) ? '0 : cnt_u + 1'b1;
            deb_m <= deb_m ^ (sync_m[1] != deb_m && cnt_m == DW'(DEB_N - 1));
            deb_u <= deb_u ^ (sync_u[1] != deb_u && cnt_u == DW'(DEB_N - 1));
         end
      end
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state    <= RUN;
         rep_cnt  <= '0;
         rep_strb <= 1'b0;
         to_cnt   <= '0;
         SEC_INC  <= 1'b0;
         MIN_INC  <= 1'b0;
         HOUR_INC <= 1'b0;
         SEC_CLR  <= 1'b0;
         BLANK_H  <= 1'b0;
         BLANK_M  <= 1'b0;
         BLANK_S  <= 1'b0;
      end else begin
         state    <= to_hit ? RUN : press_m ? mode_t'(state + 2'd1) : state;
         rep_cnt  <= !deb_u || mode_chg ? '0 : !KHZ_EN ? rep_cnt :
                     rep_hit ? RW'(REP_DLY - REP_PER) : rep_cnt + 1'b1;
         rep_strb <= deb_u && rep_hit && !mode_chg;
         to_cnt   <= !in_set || mode_chg || press_u ? '0 : to_nxt;
         SEC_INC  <= SEC_EN && state == RUN;
         HOUR_INC <= up_ev && state == SET_H;
         MIN_INC  <= up_ev && state == SET_M;
         SEC_CLR  <= up_ev && state == SET_S;
         BLANK_H  <= state == SET_H && BLINK && !deb_u;
         BLANK_M  <= state == SET_M && BLINK && !deb_u;
         BLANK_S  <= state == SET_S && BLINK && !deb_u;
      end
endmodule
